// File: rtl/axis_width_serializer_if.sv
// Bundle of the word write port and the narrow AXI4-Stream output of axis_width_serializer.
// The slave modport is the serializer's view of the bundle. The master modport is the view of the
// logic that drives it, which is the writer on one side and the stream sink on the other.
interface axis_width_serializer_if #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 32
);
  // Handshake rule for both channels: a transfer happens at a rising edge where valid and ready are
  // both 1. A source that raises valid keeps it and its payload unchanged until that transfer.
  // ready may change freely.
  logic                 wr_valid;
  logic                 wr_ready;
  logic [IN_WIDTH-1:0]  wr_data;
  logic                 m_axis_valid;
  logic                 m_axis_ready;
  logic [OUT_WIDTH-1:0] m_axis_data;
  logic                 m_axis_last;

  modport slave (
    input  wr_valid, wr_data, m_axis_ready,
    output wr_ready, m_axis_valid, m_axis_data, m_axis_last
  );

  modport master (
    output wr_valid, wr_data, m_axis_ready,
    input  wr_ready, m_axis_valid, m_axis_data, m_axis_last
  );
endinterface

// File: rtl/axis_width_serializer.sv
// Stores wide result words in a DEPTH-entry FIFO and sends each one as RATIO narrow beats,
// least significant chunk first. TLAST marks the final beat of every WORDS_PER_PKT-th word.
module axis_width_serializer #(
  parameter int IN_WIDTH      = 128,
  parameter int OUT_WIDTH     = 32,
  parameter int DEPTH         = 4,
  parameter int WORDS_PER_PKT = 1
) (
  input  logic                       axi_clk,
  input  logic                       axi_rst,
  axis_width_serializer_if.slave     bus,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       state_dbg   // 1 while the serialiser holds a word (SEND)
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int KW    = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
  localparam logic [KW-1:0] LAST_WORD = KW'(WORDS_PER_PKT - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [IN_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [IN_WIDTH-1:0] shreg;
  logic [BW-1:0]       beat_idx;
  logic [KW-1:0]       pkt_word;
  logic                push, pop, beat_fire, word_done, fifo_nonempty;

  assign fifo_nonempty = (fifo_count != '0);
  // A full FIFO refuses the write even if the serialiser pops on the same edge.
  assign bus.wr_ready  = !axi_rst && (fifo_count < FULL);
  assign push          = bus.wr_valid && bus.wr_ready;
  assign beat_fire     = (state == S_SEND) && bus.m_axis_ready;
  assign word_done     = beat_fire && (beat_idx == LAST_BEAT);

  always_ff @(posedge axi_clk) begin
    if (axi_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_nonempty) begin
          pop       = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        // Reload straight from the FIFO at the end of a word, so no idle beat goes out.
        if (word_done) begin
          if (fifo_nonempty) pop = 1'b1;
          else               state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge axi_clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      shreg    <= '0;
      beat_idx <= '0;
      pkt_word <= '0;
    end else begin
      if (word_done) pkt_word <= (pkt_word == LAST_WORD) ? '0 : pkt_word + 1'b1;
      if (pop) begin
        shreg    <= mem[rd_ptr];
        beat_idx <= '0;
      end else if (beat_fire && !word_done) begin
        shreg    <= shreg >> OUT_WIDTH;
        beat_idx <= beat_idx + 1'b1;
      end
    end
  end

  // When a word finishes and nothing is queued, the shift register is left alone,
  // so TDATA keeps the value of the last beat sent.
  assign bus.m_axis_valid = (state == S_SEND);
  assign bus.m_axis_data  = shreg[OUT_WIDTH-1:0];
  assign bus.m_axis_last  = (state == S_SEND) && (beat_idx == LAST_BEAT) && (pkt_word == LAST_WORD);
  assign state_dbg        = (state == S_SEND);
endmodule

// File: doc/axis_width_serializer.md
Name: axis_width_serializer

Overview:
- Parametrised successor of the systolic-array output buffer.
- Accepts wide result words from the array writeback over a valid/ready write port and holds them in a DEPTH-entry FIFO.
- Serialises each word, LSB chunk first, onto an AXI4-Stream master of OUT_WIDTH bits, with TLAST framing every WORDS_PER_PKT words.
- Sits between the array result collector and the DMA/AXI-Stream interconnect.

Parameters:
- IN_WIDTH, 128, width of one write word; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 32, AXI4-Stream TDATA width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- WORDS_PER_PKT, 1, words per AXI packet; TLAST is asserted on the final beat of the final word; >= 1.
- Derived: RATIO = IN_WIDTH/OUT_WIDTH (beats per word).

Ports:
- axi_clk  in  1  sole clock; all logic on its rising edge.
- axi_rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write word present.
- wr_ready  out  1  FIFO can accept a word this cycle.
- wr_data  in  IN_WIDTH  result word.
- m_axis_valid  out  1  TVALID.
- m_axis_ready  in  1  TREADY.
- m_axis_data  out  OUT_WIDTH  TDATA.
- m_axis_last  out  1  TLAST.
- fifo_count  out  clog2(DEPTH+1)  number of words stored in the FIFO, excluding the word in the serialiser.

Behaviour:
- Reset (axi_rst=1 at a rising edge): clears FIFO pointers, fifo_count=0, wr_ready=0 during reset, m_axis_valid=0, m_axis_data=0, m_axis_last=0, beat index=0, packet word counter=0.
- Reset mid-transfer drops all stored and in-flight data; no beat completes after the reset edge.
- Write port:
  - wr_ready = !axi_rst && (fifo_count < DEPTH).
  - A word is written when wr_valid && wr_ready at the rising edge.
  - wr_ready does not account for a same-cycle pop, so a full FIFO rejects writes for that cycle.
- FIFO: circular buffer with read/write pointers wrapping modulo DEPTH. fifo_count updates each edge:
  - +1 on a write only.
  - -1 on a pop only.
  - unchanged on a simultaneous write and pop.
- Serialiser states:
  - IDLE: m_axis_valid=0. If fifo_count>0, pop the head into the shift register and go to SEND with beat 0.
  - SEND: m_axis_valid=1, m_axis_data = shift register bits [OUT_WIDTH-1:0].
- Beat handshake in SEND (m_axis_valid && m_axis_ready at an edge):
  - Beat index < RATIO-1: shift right by OUT_WIDTH and increment the beat index.
  - Beat index = RATIO-1: this is the last beat of the word; increment the packet word counter modulo WORDS_PER_PKT.
    - If fifo_count>0 at that edge, pop the next word and stay in SEND with beat 0, with no bubble.
    - Otherwise go to IDLE.
- AXI stability: while m_axis_valid && !m_axis_ready, m_axis_data and m_axis_last hold their values. m_axis_valid never drops without a completed handshake, except on reset.
- m_axis_last = 1 iff beat index = RATIO-1 and packet word counter = WORDS_PER_PKT-1.
- Latency: a word accepted at edge k into an empty FIFO with the serialiser in IDLE produces beat 0 valid from edge k+1.
- Throughput: one beat per cycle while m_axis_ready=1 and the FIFO is non-empty.
- RATIO=1: every handshake completes a word; behaviour otherwise identical.
- Empty FIFO: no pop. The serialiser idles with m_axis_valid=0 and data is don't-care (held at its last value).
- Full FIFO with the serialiser stalled: wr_ready=0 and no overwrite ever occurs.
- No data is lost or duplicated under any valid/ready pattern.

Test Plan:
- Single word: after reset, write 0x44444444_33333333_22222222_11111111 with m_axis_ready=1 -> beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles starting one cycle after the write; m_axis_last=1 only on 0x44444444; then m_axis_valid=0.
- Back-to-back: write 3 words on consecutive cycles with ready=1 -> 12 contiguous beats with no bubble; fifo_count peaks at 2 then drains to 0.
- Backpressure and full:
  - Hold m_axis_ready=0 and write 6 words -> 1 word in the serialiser, fifo_count=4, wr_ready=0, words 6+ not accepted.
  - Beat 0 stays stable for 20 cycles.
  - Then toggle ready 1/0 each cycle -> all 20 beats arrive in order.
- Framing with WORDS_PER_PKT=2, DEPTH=8: write 4 words -> m_axis_last on beats 8 and 16 only.
- Reset mid-operation: assert axi_rst during beat 2 of a word with 2 words queued -> next cycle m_axis_valid=0, m_axis_last=0, fifo_count=0. A fresh write afterwards emits its beat 0 correctly, with the last flag aligned to a fresh packet.
- Simultaneous push/pop: with fifo_count=DEPTH-1, write on the same edge the serialiser pops -> fifo_count unchanged and data order is preserved. Pointer wrap is exercised by streaming 3×DEPTH words with random ready; a scoreboard matches all beats.
